// File: rtl/dual_port_ram_arbiter.sv
// dual_port_ram_arbiter: maps two requesters onto a write/read dual-port RAM,
// round-robins write-write conflicts and steers registered read data back.
module dual_port_ram_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_dout_a,
  input  logic [DATA_W-1:0] ram_dout_b,
  output logic [CNT_W-1:0]  conflict_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic              w_both_wr;
  logic              w_sel_a1;
  logic              w_b_used;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;
  logic              r_rr;
  logic              r_pend0;
  logic              r_pend1;
  logic              r_bsel0;
  logic              r_bsel1;
  logic [DATA_W-1:0] r_hold0;
  logic [DATA_W-1:0] r_hold1;
  logic [CNT_W-1:0]  r_cnt;
  // w_sel_a1: R1 owns port A (sole requester, sole writer, or conflict winner)
  always_comb begin
    w_both_wr   = req0 & wr0 & req1 & wr1;
    w_sel_a1    = req1 & (~req0 | (wr1 & ~wr0) | (w_both_wr & r_rr));
    w_b_used    = req0 & req1 & ~w_both_wr;
    gnt0        = req0 & ~(w_both_wr & r_rr);
    gnt1        = req1 & ~(w_both_wr & ~r_rr);
    ram_we      = w_sel_a1 ? wr1 : (req0 & wr0);
    ram_addr_a  = w_sel_a1 ? addr1 : (req0 ? addr0 : '0);
    ram_addr_b  = w_b_used ? (w_sel_a1 ? addr0 : addr1) : '0;
    ram_data_in = ~ram_we ? '0 : (w_sel_a1 ? wdata1 : wdata0);
    w_rd0       = r_bsel0 ? ram_dout_b : ram_dout_a;
    w_rd1       = r_bsel1 ? ram_dout_b : ram_dout_a;
    rdata0      = r_pend0 ? w_rd0 : r_hold0;
    rdata1      = r_pend1 ? w_rd1 : r_hold1;
  end
  assign rvalid0      = r_pend0;
  assign rvalid1      = r_pend1;
  assign conflict_cnt = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= 1'b0;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_bsel0 <= 1'b0;
      r_bsel1 <= 1'b0;
      r_hold0 <= '0;
      r_hold1 <= '0;
      r_cnt   <= '0;
    end else begin
      r_pend0 <= gnt0 & ~wr0;
      r_pend1 <= gnt1 & ~wr1;
      r_bsel0 <= w_sel_a1;
      r_bsel1 <= ~w_sel_a1;
      r_hold0 <= rdata0;
      r_hold1 <= rdata1;
      if (w_both_wr) r_rr <= ~r_rr;
      if (w_both_wr && r_cnt != '1) r_cnt <= r_cnt + CNT_ONE;
    end
  end
endmodule
